// File: rtl/sha3_block_padder_pkg.sv
// Shared constants and state encoding for the SHA3 block padder.
package sha3_block_padder_pkg;
  localparam int RATE_BITS       = 576;
  localparam int WORD_BITS       = 32;
  localparam int WORDS_PER_BLOCK = 18;
  localparam int CNT_BITS        = 5;
  localparam logic [7:0] PAD_START = 8'h01;
  localparam logic [7:0] PAD_END   = 8'h80;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    PAD    = 2'd1,
    DONE   = 2'd2
  } state_t;
endpackage

// File: rtl/sha3_pad_word.sv
// Combinational padding of one message word: start-of-pad byte after the
// valid bytes, plus the end-of-pad bit when the word closes the block.
module sha3_pad_word
  import sha3_block_padder_pkg::*;
(
  input  logic [WORD_BITS-1:0] in,
  input  logic                 is_last,
  input  logic [1:0]           byte_num,
  input  logic                 at_end,
  output logic [WORD_BITS-1:0] word
);
  logic [WORD_BITS-1:0] padded;

  always_comb begin
    case (byte_num)
      2'd0:    padded = {PAD_START, 24'h0};
      2'd1:    padded = {in[31:24], PAD_START, 16'h0};
      2'd2:    padded = {in[31:16], PAD_START, 8'h0};
      default: padded = {in[31:8], PAD_START};
    endcase
    if (at_end) padded[7:0] = padded[7:0] | PAD_END;
    word = is_last ? padded : in;
  end
endmodule

// File: rtl/sha3_block_padder.sv
// Packs 32-bit message words into 576-bit SHA3 rate blocks and appends
// the 0x01..0x80 padding after the final word.
module sha3_block_padder
  import sha3_block_padder_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_BITS-1:0] in,
  input  logic                 in_ready,
  input  logic                 is_last,
  input  logic [1:0]           byte_num,
  output logic                 buffer_full,
  output logic [RATE_BITS-1:0] out,
  output logic                 out_ready,
  input  logic                 f_ack
);
  state_t               state, state_nxt;
  logic [CNT_BITS-1:0]  count;
  logic                 at_end, accept, pad_fill, insert;
  logic [WORD_BITS-1:0] msg_word, ins_word;

  assign at_end = (count == CNT_BITS'(WORDS_PER_BLOCK - 1));

  sha3_pad_word u_pad (
    .in       (in),
    .is_last  (is_last),
    .byte_num (byte_num),
    .at_end   (at_end),
    .word     (msg_word)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ACCEPT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCEPT:  if (accept && is_last) state_nxt = at_end ? DONE : PAD;
      PAD:     if (at_end) state_nxt = DONE;
      default: state_nxt = state;
    endcase
  end

  // A pending block or a finished message blocks input; the f_ack cycle
  // still sees out_ready=1, so a coincident word waits one cycle.
  always_comb begin
    buffer_full = out_ready || (state != ACCEPT);
    accept      = in_ready && !buffer_full;
    pad_fill    = (state == PAD);
    insert      = accept || pad_fill;
    ins_word    = pad_fill ? (at_end ? {24'h0, PAD_END} : '0) : msg_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      out       <= '0;
      out_ready <= 1'b0;
    end else begin
      if (insert) begin
        out   <= {out[RATE_BITS-WORD_BITS-1:0], ins_word};
        count <= at_end ? '0 : count + 1'b1;
      end
      if (insert && at_end)  out_ready <= 1'b1;
      else if (f_ack)        out_ready <= 1'b0;
    end
  end
endmodule
